// File: rtl/register_writeback_if.sv
// ============================================================================
// register_writeback_if : result sources, register-file write port and query
// Rev 1.0
// ============================================================================
`default_nettype none

interface register_writeback_if #(
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [4:0]               alu_rd;
  logic [31:0]              alu_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [4:0]               ld_rd;
  logic [31:0]              ld_data;
  logic                     rf_hold;
  logic [4:0]               write_address;
  logic [31:0]              write_data;
  logic                     write_enable;
  logic [4:0]               query_address;
  logic                     query_hit;
  logic [31:0]              query_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           rf_hold, query_address,
    input  alu_ready, ld_ready, write_address, write_data, write_enable,
           query_hit, query_data, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           rf_hold, query_address,
    output alu_ready, ld_ready, write_address, write_data, write_enable,
           query_hit, query_data, count
  );
endinterface

`default_nettype wire

// File: rtl/register_writeback.sv
// ============================================================================
// register_writeback : pending-write FIFO between ALU/load results and the RF
// Rev 1.0
// ============================================================================
`default_nettype none

module register_writeback #(
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  register_writeback_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_space;
  logic          w_ld_xfer;
  logic          w_alu_xfer;
  logic [4:0]    w_push_rd;
  logic [31:0]   w_push_data;
  logic          w_push;
  logic          w_query_hit;
  logic [31:0]   w_query_data;
  logic [PW-1:0] w_idx;

  // A full buffer may still accept when the head drains this cycle.
  assign w_pop   = (r_count != '0) && !bus.rf_hold;
  assign w_space = (r_count < CW'(DEPTH)) || w_pop;

  assign bus.ld_ready  = w_space;
  assign bus.alu_ready = w_space && !bus.ld_valid;

  assign w_ld_xfer   = bus.ld_valid && w_space;
  assign w_alu_xfer  = bus.alu_valid && w_space && !bus.ld_valid;
  assign w_push_rd   = w_ld_xfer ? bus.ld_rd   : bus.alu_rd;
  assign w_push_data = w_ld_xfer ? bus.ld_data : bus.alu_data;
  // x0 writes are acknowledged but dropped
  assign w_push      = (w_ld_xfer || w_alu_xfer) && (w_push_rd != 5'd0);

  assign bus.write_enable  = w_pop;
  assign bus.write_address = (r_count != '0) ? r_rd[r_rptr]   : 5'd0;
  assign bus.write_data    = (r_count != '0) ? r_data[r_rptr] : 32'd0;
  assign bus.count         = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents need no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= w_push_rd;
      r_data[r_wptr] <= w_push_data;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    w_query_hit  = 1'b0;
    w_query_data = 32'd0;
    w_idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if ((CW'(i) < r_count) && (bus.query_address != 5'd0) &&
          (r_rd[w_idx] == bus.query_address)) begin
        w_query_hit  = 1'b1;
        w_query_data = r_data[w_idx];
      end
    end
  end

  assign bus.query_hit  = w_query_hit;
  assign bus.query_data = w_query_data;
endmodule

`default_nettype wire

// File: tb/tb_register_writeback.sv
// ============================================================================
// tb_register_writeback : directed self-checking bench for register_writeback
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_register_writeback;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  register_writeback_if #(.DEPTH(DEPTH)) bus ();

  register_writeback #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow a further 1 ns settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_data  = 32'd0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    bus.rf_hold       = 1'b0;
    bus.query_address = 5'd0;

    // reset values, before any clock edge
    #2;
    chk("rst_we",    32'(bus.write_enable), 32'd0);
    chk("rst_count", 32'(bus.count),        32'd0);
    chk("rst_waddr", 32'(bus.write_address), 32'd0);
    chk("rst_ldrdy", 32'(bus.ld_ready),     32'd1);
    chk("rst_alurdy",32'(bus.alu_ready),    32'd1);
    chk("rst_qhit",  32'(bus.query_hit),    32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // single ALU result, next-cycle write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h11;
    bus.query_address = 5'd5;
    #1;
    chk("t1_alurdy", 32'(bus.alu_ready), 32'd1);
    chk("t1_q_same", 32'(bus.query_hit), 32'd0);
    tick();
    idle();
    #1;
    chk("t1_we",    32'(bus.write_enable),  32'd1);
    chk("t1_waddr", 32'(bus.write_address), 32'd5);
    chk("t1_wdata", bus.write_data,         32'h11);
    chk("t1_qhit",  32'(bus.query_hit),     32'd1);
    chk("t1_qdata", bus.query_data,         32'h11);
    tick();
    #1;
    chk("t1_cnt0",  32'(bus.count),         32'd0);
    chk("t1_we0",   32'(bus.write_enable),  32'd0);
    chk("t1_addr0", 32'(bus.write_address), 32'd0);

    // load beats ALU
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd3; bus.ld_data  = 32'hAA;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'hBB;
    #1;
    chk("t2_ldrdy",  32'(bus.ld_ready),  32'd1);
    chk("t2_alurdy", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    #1;
    chk("t2_waddr1", 32'(bus.write_address), 32'd3);
    chk("t2_wdata1", bus.write_data,         32'hAA);
    chk("t2_alurdy1",32'(bus.alu_ready),     32'd1);
    tick();
    idle();
    #1;
    chk("t2_waddr2", 32'(bus.write_address), 32'd4);
    chk("t2_wdata2", bus.write_data,         32'hBB);
    chk("t2_we2",    32'(bus.write_enable),  32'd1);
    tick();
    #1;
    chk("t2_cnt0",   32'(bus.count), 32'd0);

    // fill under hold, then drain in order while a new load waits
    bus.rf_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(k); bus.ld_data = 32'h100 + 32'(k);
      tick();
    end
    bus.ld_rd = 5'd9; bus.ld_data = 32'h99;
    #1;
    chk("t3_cnt4",  32'(bus.count),        32'd4);
    chk("t3_full",  32'(bus.ld_ready),     32'd0);
    chk("t3_hold",  32'(bus.write_enable), 32'd0);
    tick();
    chk("t3_cnt4b", 32'(bus.count),        32'd4);
    bus.rf_hold = 1'b0;
    #1;
    chk("t3_rdy_pop", 32'(bus.ld_ready),     32'd1);
    chk("t3_we",      32'(bus.write_enable), 32'd1);
    chk("t3_w1",      32'(bus.write_address), 32'd1);
    chk("t3_d1",      bus.write_data,         32'h101);
    tick();
    idle();
    #1;
    chk("t3_cnt_pp", 32'(bus.count),         32'd4);
    chk("t3_w2",     32'(bus.write_address), 32'd2);
    chk("t3_d2",     bus.write_data,         32'h102);
    tick();
    chk("t3_w3",     32'(bus.write_address), 32'd3);
    tick();
    chk("t3_w4",     32'(bus.write_address), 32'd4);
    chk("t3_d4",     bus.write_data,         32'h104);
    tick();
    chk("t3_w9",     32'(bus.write_address), 32'd9);
    chk("t3_d9",     bus.write_data,         32'h99);
    tick();
    chk("t3_empty",  32'(bus.count),         32'd0);

    // youngest match wins
    bus.rf_hold = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1;
    tick();
    bus.ld_data = 32'h2;
    tick();
    idle();
    bus.query_address = 5'd7;
    #1;
    chk("t4_qhit",   32'(bus.query_hit), 32'd1);
    chk("t4_qdata",  bus.query_data,     32'h2);
    bus.query_address = 5'd0;
    #1;
    chk("t4_q0hit",  32'(bus.query_hit), 32'd0);
    chk("t4_q0data", bus.query_data,     32'h0);
    bus.query_address = 5'd8;
    #1;
    chk("t4_q8hit",  32'(bus.query_hit), 32'd0);
    chk("t4_q8data", bus.query_data,     32'h0);

    // rd=0 acknowledged, not enqueued
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    #1;
    chk("t5_rdy", 32'(bus.alu_ready), 32'd1);
    tick();
    chk("t5_cnt", 32'(bus.count), 32'd2);

    // third entry, then reset mid-operation
    bus.alu_rd = 5'd9; bus.alu_data = 32'h3;
    tick();
    idle();
    bus.rf_hold = 1'b0;
    bus.query_address = 5'd7;
    #1;
    chk("t6_cnt3",  32'(bus.count),         32'd3);
    chk("t6_we",    32'(bus.write_enable),  32'd1);
    chk("t6_head",  32'(bus.write_address), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we",   32'(bus.write_enable), 32'd0);
    chk("t6_rst_cnt",  32'(bus.count),        32'd0);
    chk("t6_rst_qhit", 32'(bus.query_hit),    32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_no_we", 32'(bus.write_enable), 32'd0);
      tick();
    end

    // first transfer after reset; rd=0 produces no write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h77;
    tick();
    bus.alu_rd = 5'd12; bus.alu_data = 32'hC;
    #1;
    chk("t7_rd0_we",  32'(bus.write_enable), 32'd0);
    chk("t7_rd0_cnt", 32'(bus.count),        32'd0);
    tick();
    idle();
    #1;
    chk("t7_we",    32'(bus.write_enable),  32'd1);
    chk("t7_waddr", 32'(bus.write_address), 32'd12);
    chk("t7_wdata", bus.write_data,         32'hC);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/register_writeback.md
REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of pending-write buffer entries (power of two, 2..16).
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  alu_valid  in  1  ALU result offered
  alu_ready  out  1  ALU result accepted this cycle
  alu_rd  in  5  ALU destination register
  alu_data  in  32  ALU result
  ld_valid  in  1  load result offered
  ld_ready  out  1  load result accepted this cycle
  ld_rd  in  5  load destination register
  ld_data  in  32  load result
  rf_hold  in  1  register-file write port unavailable this cycle
  write_address  out  5  register-file write address
  write_data  out  32  register-file write data
  write_enable  out  1  register-file write strobe
  query_address  in  5  operand-fetch register being read
  query_hit  out  1  a pending write to query_address exists
  query_data  out  32  youngest pending data for query_address
  count  out  $clog2(DEPTH)+1  pending-entry count

Function
REQ-003 The block SHALL hold pending writes in a circular FIFO of DEPTH entries {rd[4:0], data[31:0]}, with read pointer, write pointer and count registers.
REQ-004 Acceptance: at most one source per cycle; the load source SHALL have priority over the ALU source.
REQ-005 ld_ready SHALL be 1 when count < DEPTH, or when count == DEPTH and a pop occurs this cycle; otherwise 0.
REQ-006 alu_ready SHALL equal the ld_ready condition AND NOT ld_valid.
REQ-007 A transfer SHALL occur when valid && ready; ready SHALL NOT depend on valid of the same source.
REQ-008 A transfer with rd == 0 SHALL be acknowledged (ready asserted) but SHALL NOT be enqueued.
REQ-009 Pop: when count > 0 and rf_hold == 0, the head entry SHALL be written and removed at the rising edge.
REQ-010 write_enable SHALL equal (count > 0) && !rf_hold, combinationally from state and rf_hold; write_address/write_data SHALL show the head entry whenever count > 0 and SHALL be 0 when count == 0.
REQ-011 Latency: a result accepted at edge N SHALL appear on write_enable/address/data in the cycle after edge N if it is at the head and rf_hold is low.
REQ-012 Writes SHALL reach the register file in acceptance order.
REQ-013 Simultaneous push and pop SHALL leave count unchanged; the entry pushed SHALL NOT be popped in the same cycle.
REQ-014 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-015 Query: combinational; query_hit SHALL be 1 iff query_address != 0 and some valid entry (including the head being written this cycle) has rd == query_address.
REQ-016 query_data SHALL be the data of the youngest matching entry, and 0 when query_hit == 0.
REQ-017 Entries accepted in the current cycle SHALL NOT be visible to the query until the next cycle.

Reset
REQ-018 While rst_n == 0, regardless of clk, count, pointers SHALL be 0 and all entries SHALL be invalid; write_enable, write_address, write_data, query_hit, query_data SHALL be 0; ld_ready and alu_ready SHALL be 1.
REQ-019 Reset asserted mid-operation SHALL discard all pending entries without issuing their writes.
REQ-020 After rst_n rises, the first transfer SHALL be accepted at the first rising edge with valid high.

Verification
REQ-021 ALU (rd=5, data=0x11) at edge 1, rf_hold=0 -> next cycle write_enable=1, write_address=5, write_data=0x11; count 0 afterwards.
REQ-022 ld_valid and alu_valid both high (ld rd=3/0xAA, alu rd=4/0xBB) -> ld_ready=1, alu_ready=0; rd 3 written first, ALU held until next cycle.
REQ-023 rf_hold=1, DEPTH=4, push rd=1..4 -> count=4, ld_ready=0; release rf_hold -> writes 1,2,3,4 on four consecutive cycles; with a new valid offered while full, that ready rises in the first pop cycle.
REQ-024 Pending rd=7/0x1 then rd=7/0x2 with rf_hold=1, query_address=7 -> query_hit=1, query_data=0x2; query_address=0 or 8 -> query_hit=0, query_data=0.
REQ-025 Transfer with rd=0 -> ready=1, count unchanged, no write_enable pulse.
REQ-026 Three entries pending, rst_n driven low between edges -> write_enable, count, query_hit go to 0 immediately; no pending write issued after release.
